// File: rtl/mor1kx_marocchino_pkg.sv
//------------------------------------------------------------------------------
// Module : mor1kx_marocchino_pkg
// Brief  : Shared definitions for the MAROCCHINO in-order writeback mux: unit-ID
//          width helper, exception bit indices, OCB entry layout, FSM encoding.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package mor1kx_marocchino_pkg;

    // Unit-ID width; never narrower than one bit so a single-unit build still has a port.
    function automatic int uidw(input int num_units);
        return (num_units > 1) ? $clog2(num_units) : 1;
    endfunction

    localparam int IBUS_ERR   = 0;
    localparam int IPAGEFAULT = 1;
    localparam int ITLB_MISS  = 2;
    localparam int IBUS_ALIGN = 3;
    localparam int ILLEGAL    = 4;
    localparam int SYSCALL    = 5;
    localparam int TRAP       = 6;
    localparam int DBUS_ERR   = 7;
    localparam int DPAGEFAULT = 8;
    localparam int DTLB_MISS  = 9;
    localparam int ALIGN      = 10;

    // OCB entry is packed as {unit, rfd, rf_wb, pc, ds}, ds in bit 0.
    function automatic int ocb_entry_width(input int uw, input int rw, input int ow);
        return uw + rw + 1 + ow + 1;
    endfunction

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_HALT = 1'b1;

endpackage

`default_nettype wire

// File: rtl/mor1kx_ocb_marocchino.sv
//------------------------------------------------------------------------------
// Module : mor1kx_ocb_marocchino
// Brief  : Generic synchronous FIFO (order control buffer) with flush, count,
//          full/empty flags and head-of-queue data. DEPTH must be a power of 2.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mor1kx_ocb_marocchino #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_flush,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_data,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_data,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] c_depth = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == c_depth);
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_data  = r_mem[r_rd_ptr];

    // A full FIFO refuses a push even if a pop happens in the same cycle.
    assign w_push = i_push & ~o_full & ~i_flush;
    assign w_pop  = i_pop & ~o_empty & ~i_flush;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/mor1kx_wb_ocb_mux_marocchino.sv
//------------------------------------------------------------------------------
// Module : mor1kx_wb_ocb_mux_marocchino
// Brief  : In-order writeback stage: retires the OCB head once its unit result is
//          valid, registers the muxed result and halts on exceptions until flush.
//          Optional macro MOR1KX_WBM_FLAGS_EN enables the SR[F] set/clear path.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mor1kx_wb_ocb_mux_marocchino
    import mor1kx_marocchino_pkg::*;
#(
    parameter int OPTION_OPERAND_WIDTH = 32,
    parameter int OPTION_RF_ADDR_WIDTH = 5,
    parameter int NUM_UNITS            = 4,
    parameter int OCB_DEPTH            = 4,
    parameter int EXCEPT_WIDTH         = 11
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      pipeline_flush_i,
    input  logic                                      issue_valid_i,
    input  logic [uidw(NUM_UNITS)-1:0]                issue_unit_i,
    input  logic [OPTION_RF_ADDR_WIDTH-1:0]           issue_rfd_adr_i,
    input  logic                                      issue_rf_wb_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0]           issue_pc_i,
    input  logic                                      issue_delay_slot_i,
    output logic                                      issue_ready_o,
    input  logic [NUM_UNITS-1:0]                      unit_valid_i,
    input  logic [NUM_UNITS*OPTION_OPERAND_WIDTH-1:0] unit_result_i,
    input  logic [NUM_UNITS*EXCEPT_WIDTH-1:0]         unit_except_i,
    input  logic [NUM_UNITS-1:0]                      unit_flag_set_i,
    input  logic [NUM_UNITS-1:0]                      unit_flag_clear_i,
    output logic [NUM_UNITS-1:0]                      unit_ack_o,
    input  logic                                      wb_stall_i,
    output logic                                      wb_valid_o,
    output logic [OPTION_OPERAND_WIDTH-1:0]           wb_result_o,
    output logic [OPTION_RF_ADDR_WIDTH-1:0]           wb_rfd_adr_o,
    output logic                                      wb_rf_wb_o,
    output logic [OPTION_OPERAND_WIDTH-1:0]           pc_wb_o,
    output logic                                      wb_delay_slot_o,
    output logic [EXCEPT_WIDTH-1:0]                   wb_except_o,
    output logic                                      wb_excepts_any_o,
    output logic                                      wb_flag_set_o,
    output logic                                      wb_flag_clear_o,
    output logic [$clog2(OCB_DEPTH):0]                ocb_count_o
);

    localparam int UIDW    = uidw(NUM_UNITS);
    localparam int OW      = OPTION_OPERAND_WIDTH;
    localparam int RW      = OPTION_RF_ADDR_WIDTH;
    localparam int EW      = EXCEPT_WIDTH;
    localparam int ENTRY_W = ocb_entry_width(UIDW, RW, OW);
    localparam int PC_L    = 1;
    localparam int RFWB_B  = OW + 1;
    localparam int RFD_L   = OW + 2;
    localparam int UNIT_L  = OW + 2 + RW;

    logic [ENTRY_W-1:0] w_push_entry;
    logic [ENTRY_W-1:0] w_head;
    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_retire;

    logic [UIDW-1:0]    w_head_unit;
    logic [RW-1:0]      w_head_rfd;
    logic               w_head_rf_wb;
    logic [OW-1:0]      w_head_pc;
    logic               w_head_ds;

    logic               w_head_valid;
    logic [NUM_UNITS-1:0] w_head_onehot;
    logic [OW-1:0]      w_sel_result;
    logic [EW-1:0]      w_sel_except;

    logic [0:0]         r_state;
    logic [0:0]         w_state_nxt;

    logic               r_wb_valid;
    logic [OW-1:0]      r_wb_result;
    logic [RW-1:0]      r_wb_rfd;
    logic               r_wb_rf_wb;
    logic [OW-1:0]      r_wb_pc;
    logic               r_wb_ds;
    logic [EW-1:0]      r_wb_except;

    assign w_push_entry = {issue_unit_i, issue_rfd_adr_i, issue_rf_wb_i, issue_pc_i, issue_delay_slot_i};
    assign issue_ready_o = ~w_full;
    assign w_push        = issue_valid_i & issue_ready_o & ~pipeline_flush_i;

    mor1kx_ocb_marocchino #(
        .WIDTH (ENTRY_W),
        .DEPTH (OCB_DEPTH)
    ) u_ocb (
        .clk     (clk),
        .rst     (rst),
        .i_flush (pipeline_flush_i),
        .i_push  (w_push),
        .i_data  (w_push_entry),
        .i_pop   (w_retire),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (ocb_count_o)
    );

    assign w_head_ds    = w_head[0];
    assign w_head_pc    = w_head[PC_L +: OW];
    assign w_head_rf_wb = w_head[RFWB_B];
    assign w_head_rfd   = w_head[RFD_L +: RW];
    assign w_head_unit  = w_head[UNIT_L +: UIDW];

    // Compare-based select keeps non-power-of-2 unit counts safe from out-of-range IDs.
    always_comb begin
        w_head_valid  = 1'b0;
        w_head_onehot = '0;
        w_sel_result  = '0;
        w_sel_except  = '0;
        for (int u = 0; u < NUM_UNITS; u++) begin
            if (w_head_unit == UIDW'(u)) begin
                w_head_valid     = unit_valid_i[u];
                w_head_onehot[u] = 1'b1;
                w_sel_result     = unit_result_i[u*OW +: OW];
                w_sel_except     = unit_except_i[u*EW +: EW];
            end
        end
    end

    assign w_retire = (r_state == ST_RUN) & ~w_empty & w_head_valid & ~wb_stall_i & ~pipeline_flush_i;

    always_ff @(posedge clk) begin
        if (rst || pipeline_flush_i) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN:  if (w_retire && (|w_sel_except)) w_state_nxt = ST_HALT;
            ST_HALT: if (pipeline_flush_i) w_state_nxt = ST_RUN;
            default: w_state_nxt = ST_RUN;
        endcase
    end

    always_comb begin
        unit_ack_o = '0;
        if (w_retire) begin
            unit_ack_o = w_head_onehot;
        end
    end

    // Data registers only change on a retire; a flush leaves them untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wb_result <= '0;
            r_wb_rfd    <= '0;
            r_wb_pc     <= '0;
            r_wb_ds     <= 1'b0;
        end else if (w_retire) begin
            r_wb_result <= w_sel_result;
            r_wb_rfd    <= w_head_rfd;
            r_wb_pc     <= w_head_pc;
            r_wb_ds     <= w_head_ds;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || pipeline_flush_i) begin
            r_wb_valid  <= 1'b0;
            r_wb_rf_wb  <= 1'b0;
            r_wb_except <= '0;
        end else begin
            r_wb_valid  <= w_retire;
            r_wb_rf_wb  <= w_retire & w_head_rf_wb & ~(|w_sel_except);
            r_wb_except <= w_retire ? w_sel_except : '0;
        end
    end

`ifdef MOR1KX_WBM_FLAGS_EN
    logic w_sel_fset;
    logic w_sel_fclr;
    logic r_wb_fset;
    logic r_wb_fclr;

    always_comb begin
        w_sel_fset = 1'b0;
        w_sel_fclr = 1'b0;
        for (int u = 0; u < NUM_UNITS; u++) begin
            if (w_head_unit == UIDW'(u)) begin
                w_sel_fset = unit_flag_set_i[u];
                w_sel_fclr = unit_flag_clear_i[u];
            end
        end
    end

    // Clear dominates when a unit reports both.
    always_ff @(posedge clk) begin
        if (rst || pipeline_flush_i) begin
            r_wb_fset <= 1'b0;
            r_wb_fclr <= 1'b0;
        end else begin
            r_wb_fset <= w_retire & w_sel_fset & ~w_sel_fclr;
            r_wb_fclr <= w_retire & w_sel_fclr;
        end
    end

    assign wb_flag_set_o   = r_wb_fset;
    assign wb_flag_clear_o = r_wb_fclr;
`else
    logic w_unused_flags;
    assign w_unused_flags  = ^{unit_flag_set_i, unit_flag_clear_i};
    assign wb_flag_set_o   = 1'b0;
    assign wb_flag_clear_o = 1'b0;
`endif

    assign wb_valid_o       = r_wb_valid;
    assign wb_result_o      = r_wb_result;
    assign wb_rfd_adr_o     = r_wb_rfd;
    assign wb_rf_wb_o       = r_wb_rf_wb;
    assign pc_wb_o          = r_wb_pc;
    assign wb_delay_slot_o  = r_wb_ds;
    assign wb_except_o      = r_wb_except;
    assign wb_excepts_any_o = |r_wb_except;

endmodule

`default_nettype wire
